// File: rtl/seg_scan_decoder.sv
// Decodes a 4-digit multiplexed, active-low 7-segment display bus.
// Each complete frame is converted from BCD to binary.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        fpga_clk1,
  input  logic        reset,
  input  logic        seg0,
  input  logic        seg1,
  input  logic        seg2,
  input  logic        seg3,
  input  logic        seg4,
  input  logic        seg5,
  input  logic        seg6,
  input  logic        an0,
  input  logic        an1,
  input  logic        an2,
  input  logic        an3,
  output logic [15:0] value,
  output logic        valid,
  output logic [15:0] bcd,
  output logic        err
);

  localparam int unsigned WORD_W  = 11;
  localparam int unsigned CNT_W   = $clog2(STABLE_CYCLES);
  localparam int unsigned TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned ACC_W   = 14;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [TMR_W-1:0] TMR_END = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WORD_W-1:0]  w_raw;
  logic [WORD_W-1:0]  r_sync1;
  logic [WORD_W-1:0]  r_sync2;
  logic [WORD_W-1:0]  r_prev;
  logic [CNT_W-1:0]   r_cnt;
  logic [TMR_W-1:0]   r_timer;
  logic [3:0]         r_mask;
  logic [3:0]         w_mask_next;
  logic [3:0]         r_slot [4];
  logic [3:0]         r_snap [4];
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_next;
  logic [1:0]         r_step;
  logic [3:0]         w_an;
  logic [6:0]         w_seg;
  logic [1:0]         w_slot;
  logic               w_one_hot;
  logic [3:0]         w_dig;
  logic               w_dig_ok;
  logic               w_same;
  logic               w_accept;
  logic               w_acc_good;
  logic               w_acc_bad;
  logic               w_partial;
  logic               w_timeout;
  logic               w_snap;
  logic               w_last_step;

  assign w_raw = {an3, an2, an1, an0, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

  // Two-flop input synchronisers
  always_ff @(posedge fpga_clk1 or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_an  = ~r_sync2[10:7];
  assign w_seg = r_sync2[6:0];
  assign w_same = (r_sync2 == r_prev);

  always_comb begin
    w_one_hot = 1'b1;
    w_slot    = 2'd0;
    case (w_an)
      4'b0001: w_slot = 2'd0;
      4'b0010: w_slot = 2'd1;
      4'b0100: w_slot = 2'd2;
      4'b1000: w_slot = 2'd3;
      default: w_one_hot = 1'b0;
    endcase
  end

  always_comb begin
    w_dig    = 4'd0;
    w_dig_ok = 1'b1;
    case (w_seg)
      7'b1000000: w_dig = 4'd0;
      7'b1111001: w_dig = 4'd1;
      7'b0100100: w_dig = 4'd2;
      7'b0110000: w_dig = 4'd3;
      7'b0011001: w_dig = 4'd4;
      7'b0010010: w_dig = 4'd5;
      7'b0000010: w_dig = 4'd6;
      7'b1111000: w_dig = 4'd7;
      7'b0000000: w_dig = 4'd8;
      7'b0010000: w_dig = 4'd9;
      7'b1111111: w_dig = 4'd0;
      default:    w_dig_ok = 1'b0;
    endcase
  end

  // Accept fires on the cycle the counter climbs to its saturation value
  assign w_accept   = w_same && (r_cnt == CNT_HIT) && w_one_hot;
  assign w_acc_good = w_accept && w_dig_ok;
  assign w_acc_bad  = w_accept && !w_dig_ok;

  assign w_partial = (r_mask != 4'h0) && (r_mask != 4'hF);
  assign w_timeout = w_partial && (r_timer == TMR_END);

  always_ff @(posedge fpga_clk1 or negedge reset) begin
    if (!reset) begin
      r_prev  <= '0;
      r_cnt   <= '0;
      r_timer <= '0;
    end else begin
      r_prev <= r_sync2;
      if (!w_same) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_timeout || (r_mask == 4'h0)) begin
        r_timer <= '0;
      end else if (w_partial) begin
        r_timer <= r_timer + TMR_W'(1);
      end
    end
  end

  // Clears apply before a fresh capture so a digit landing with a snapshot starts the next frame
  always_comb begin
    w_mask_next = r_mask;
    if (w_snap || w_timeout || w_acc_bad) begin
      w_mask_next = 4'h0;
    end
    if (w_acc_good) begin
      w_mask_next = w_mask_next | w_an;
    end
  end

  always_ff @(posedge fpga_clk1 or negedge reset) begin
    if (!reset) begin
      r_mask <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        r_slot[i] <= 4'd0;
      end
    end else begin
      r_mask <= w_mask_next;
      if (w_acc_good) begin
        r_slot[w_slot] <= w_dig;
      end
    end
  end

  always_ff @(posedge fpga_clk1 or negedge reset) begin
    if (!reset) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_snap       = 1'b0;
    w_last_step  = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (r_mask == 4'hF) begin
          w_snap       = 1'b1;
          w_state_next = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (r_step == 2'd3) begin
          w_last_step  = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_COLLECT;
      default: w_state_next = S_COLLECT;
    endcase
  end

  // acc*10 + digit, thousands first
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {10'd0, r_snap[r_step]};

  always_ff @(posedge fpga_clk1 or negedge reset) begin
    if (!reset) begin
      r_acc  <= '0;
      r_step <= 2'd0;
      value  <= 16'd0;
      bcd    <= 16'd0;
      valid  <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_snap[i] <= 4'd0;
      end
    end else begin
      valid <= w_last_step;
      err   <= w_acc_bad || w_timeout;
      if (w_snap) begin
        r_acc  <= '0;
        r_step <= 2'd0;
        for (int i = 0; i < 4; i++) begin
          r_snap[i] <= r_slot[i];
        end
      end else if (r_state == S_CONVERT) begin
        r_acc  <= w_acc_next;
        r_step <= r_step + 2'd1;
      end
      if (w_last_step) begin
        value <= {2'b00, w_acc_next};
        bcd   <= {r_snap[0], r_snap[1], r_snap[2], r_snap[3]};
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: frames are scanned onto the display bus,
// expected results are queued from digit arithmetic and checked when valid pulses.
module tb_seg_scan_decoder;

  localparam int unsigned STABLE = 16;
  localparam int unsigned TMO    = 3000;
  localparam int          BLANK  = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  tb_seg;
  logic [3:0]  tb_an;
  logic [15:0] value;
  logic        valid;
  logic [15:0] bcd;
  logic        err;

  typedef struct {
    logic [15:0] value;
    logic [15:0] bcd;
  } exp_t;

  exp_t q[$];
  int   n_cmp      = 0;
  int   n_bad      = 0;
  int   err_seen   = 0;
  int   err_exp    = 0;
  int   valid_seen = 0;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .fpga_clk1(clk),
    .reset    (rst_n),
    .seg0     (tb_seg[0]),
    .seg1     (tb_seg[1]),
    .seg2     (tb_seg[2]),
    .seg3     (tb_seg[3]),
    .seg4     (tb_seg[4]),
    .seg5     (tb_seg[5]),
    .seg6     (tb_seg[6]),
    .an0      (tb_an[0]),
    .an1      (tb_an[1]),
    .an2      (tb_an[2]),
    .an3      (tb_an[3]),
    .value    (value),
    .valid    (valid),
    .bcd      (bcd),
    .err      (err)
  );

  // Patterns listed as {g,f,e,d,c,b,a}, active-low
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic [3:0] an_l, input logic [6:0] s, input int cycles);
    tb_an  = an_l;
    tb_seg = s;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int cycles);
    drive(4'hF, 7'h7F, cycles);
  endtask

  task automatic show(input int pos, input int d, input int cycles);
    drive(~(4'b0001 << pos), seg_of(d), cycles);
  endtask

  // Reference: blanks read as zero, value is the positional decimal sum
  task automatic push_exp(input int d0, input int d1, input int d2, input int d3);
    exp_t e;
    int v0, v1, v2, v3;
    v0 = (d0 == BLANK) ? 0 : d0;
    v1 = (d1 == BLANK) ? 0 : d1;
    v2 = (d2 == BLANK) ? 0 : d2;
    v3 = (d3 == BLANK) ? 0 : d3;
    e.value = 16'(v0 * 1000 + v1 * 100 + v2 * 10 + v3);
    e.bcd   = {4'(v0), 4'(v1), 4'(v2), 4'(v3)};
    q.push_back(e);
  endtask

  task automatic scan_frame(input int d0, input int d1, input int d2, input int d3,
                            input int dwell, input int rot);
    int d[4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    push_exp(d0, d1, d2, d3);
    for (int k = 0; k < 4; k++) begin
      show((k + rot) % 4, d[(k + rot) % 4], dwell);
    end
  endtask

  // Monitor: pop and compare on each valid pulse, count err pulses
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid) begin
        valid_seen++;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: value=%0d bcd=%0h, none expected (t=%0t)",
                   value, bcd, $time);
        end else begin
          e = q.pop_front();
          check("value", 32'(value), 32'(e.value));
          check("bcd", 32'(bcd), 32'(e.bcd));
        end
      end
      if (rst_n && err) err_seen++;
    end
  end

  initial begin
    int vs;
    int r0, r1, r2, r3, dw, rt;
    rst_n  = 1'b0;
    tb_an  = 4'hF;
    tb_seg = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", 32'(value), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    idle(10);

    scan_frame(1, 2, 3, 4, 64, 0);
    idle(60);
    check("valid_once", 32'(valid_seen), 32'd1);
    scan_frame(9, 9, 9, 9, 64, 0);
    idle(60);
    scan_frame(0, 0, 0, 0, 64, 0);
    idle(60);
    check("zero_frame_valid", 32'(valid_seen), 32'd3);
    scan_frame(BLANK, BLANK, 4, 2, 64, 0);
    idle(60);
    check("no_err_clean", 32'(err_seen), 32'(err_exp));

    // Invalid hundreds pattern wipes the partial frame
    vs = valid_seen;
    show(0, 1, 64);
    show(2, 3, 64);
    show(3, 4, 64);
    drive(4'b1101, 7'b0110110, 64);
    idle(40);
    err_exp++;
    check("bad_pattern_err", 32'(err_seen), 32'(err_exp));
    show(1, 5, 64);
    idle(40);
    check("no_valid_after_bad", 32'(valid_seen), 32'(vs));
    scan_frame(0, 0, 0, 7, 64, 0);
    idle(60);

    // Short glitch inside the units dwell is ignored
    push_exp(3, 1, 9, 5);
    show(0, 3, 64);
    show(1, 1, 64);
    show(2, 9, 64);
    show(3, 5, 8);
    show(3, 8, STABLE - 2);
    show(3, 5, 64);
    idle(60);

    for (int r = 0; r < 8; r++) begin
      r0 = int'($urandom_range(0, 10));
      r1 = int'($urandom_range(0, 10));
      r2 = int'($urandom_range(0, 10));
      r3 = int'($urandom_range(0, 10));
      dw = int'($urandom_range(24, 80));
      rt = int'($urandom_range(0, 3));
      scan_frame(r0, r1, r2, r3, dw, rt);
      idle(int'($urandom_range(30, 50)));
    end
    idle(60);
    check("queue_drained", 32'(q.size()), 32'd0);
    check("no_err_random", 32'(err_seen), 32'(err_exp));

    // Units never scanned: frame times out
    vs = valid_seen;
    show(0, 6, 64);
    show(1, 7, 64);
    show(2, 8, 64);
    idle(int'(TMO) + 200);
    err_exp++;
    check("timeout_err", 32'(err_seen), 32'(err_exp));
    check("timeout_no_valid", 32'(valid_seen), 32'(vs));

    // Reset lands mid-conversion of a completed frame
    show(0, 4, 64);
    show(1, 3, 64);
    show(2, 2, 64);
    show(3, 1, 20);
    rst_n = 1'b0;
    #2;
    check("abort_value", 32'(value), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(80);
    check("no_valid_after_abort", 32'(valid_seen), 32'(vs));
    check("value_after_abort", 32'(value), 32'd0);

    scan_frame(5, 6, 7, 8, 64, 0);
    idle(60);
    check("final_drained", 32'(q.size()), 32'd0);
    check("final_err", 32'(err_seen), 32'(err_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
